// File: rtl/uart_transmitter.sv
// UART transmitter: one-entry holding register, LSB-first framing,
// optional parity, one or two stop bits and line break generation.
module uart_transmitter #(
  parameter int CLOCK_DIVISOR_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     dataBits,
  input  logic                           hasParity,
  input  logic [1:0]                     parityMode,
  input  logic                           extraStopBit,
  input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
  input  logic [7:0]                     dataIn,
  input  logic                           dataValid,
  output logic                           dataReady,
  input  logic                           sendBreak,
  output logic                           tx,
  output logic                           busy
);

  localparam int W = CLOCK_DIVISOR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    BREAK
  } state_t;

  state_t state, state_n;

  logic [7:0]   hold_q;
  logic         hold_full;
  logic [7:0]   shift_q, shift_n;
  logic [2:0]   bit_q, bit_n;
  logic [W-1:0] cnt_q, div_q;
  logic [1:0]   bits_q;
  logic         par_en_q, par_q, two_stop_q;

  logic       tx_n, load, brk_rel, frame_end;
  logic       tc, last_bit, accept, par_calc;
  logic [7:0] mask, masked;

  assign mask     = 8'hff >> (2'd3 - dataBits);
  assign masked   = hold_q & mask;
  assign tc       = (cnt_q == div_q);
  assign last_bit = (bit_q == ({1'b0, bits_q} + 3'd4));
  assign accept   = dataValid && !hold_full;

  assign dataReady = !hold_full;
  assign busy      = (state != IDLE);

  always_comb begin
    par_calc = 1'b0;
    unique case (parityMode)
      2'b00: par_calc = 1'b0;
      2'b11: par_calc = 1'b1;
      2'b10: par_calc = ^masked;
      default: par_calc = ~^masked;
    endcase
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift_q;
    bit_n     = bit_q;
    load      = 1'b0;
    brk_rel   = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      IDLE: begin
        if (sendBreak) begin
          state_n = BREAK;
        end else if (hold_full) begin
          state_n = START;
          load    = 1'b1;
        end
      end
      START: begin
        if (tc) state_n = DATA;
      end
      DATA: begin
        if (tc) begin
          if (last_bit) begin
            state_n = par_en_q ? PARITY : STOP1;
          end else begin
            bit_n   = bit_q + 3'd1;
            shift_n = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (tc) state_n = STOP1;
      end
      STOP1: begin
        if (tc) begin
          if (two_stop_q) state_n = STOP2;
          else frame_end = 1'b1;
        end
      end
      STOP2: begin
        if (tc) frame_end = 1'b1;
      end
      BREAK: begin
        if (!sendBreak) begin
          state_n = STOP1;
          brk_rel = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Chain straight into the next frame when a byte is waiting.
    if (frame_end) begin
      if (hold_full && !sendBreak) begin
        state_n = START;
        load    = 1'b1;
      end else begin
        state_n = IDLE;
      end
    end

    if (load) begin
      shift_n = hold_q;
      bit_n   = 3'd0;
    end

    tx_n = 1'b1;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_q;
      BREAK:   tx_n = 1'b0;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      tx    <= tx_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= 8'd0;
      hold_full  <= 1'b0;
      shift_q    <= 8'd0;
      bit_q      <= 3'd0;
      cnt_q      <= '0;
      div_q      <= '0;
      bits_q     <= 2'd0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      shift_q <= shift_n;
      bit_q   <= bit_n;

      if (accept) begin
        hold_q    <= dataIn;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (state_n != state || tc ||
          state == IDLE || state == BREAK) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + W'(1);
      end

      if (load) begin
        div_q      <= clockDivisor;
        bits_q     <= dataBits;
        par_en_q   <= hasParity;
        par_q      <= par_calc;
        two_stop_q <= extraStopBit;
      end else if (brk_rel) begin
        div_q      <= clockDivisor;
        two_stop_q <= extraStopBit;
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: per-cycle tx/busy waveform compared
// against a queue built from a frame-level model.
module tb_uart_transmitter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dataBits;
  logic        hasParity;
  logic [1:0]  parityMode;
  logic        extraStopBit;
  logic [23:0] clockDivisor;
  logic [7:0]  dataIn;
  logic        dataValid;
  logic        dataReady;
  logic        sendBreak;
  logic        tx;
  logic        busy;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic tx;
    logic busy;
  } exp_t;

  exp_t expq[$];

  always #5 clk = ~clk;

  uart_transmitter #(.CLOCK_DIVISOR_WIDTH(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .dataBits     (dataBits),
    .hasParity    (hasParity),
    .parityMode   (parityMode),
    .extraStopBit (extraStopBit),
    .clockDivisor (clockDivisor),
    .dataIn       (dataIn),
    .dataValid    (dataValid),
    .dataReady    (dataReady),
    .sendBreak    (sendBreak),
    .tx           (tx),
    .busy         (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample at the falling edge, empty queue means idle line.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (expq.size() > 0) e = expq.pop_front();
    else e = '{tx: 1'b1, busy: 1'b0};
    check("tx", {31'd0, tx}, {31'd0, e.tx});
    check("busy", {31'd0, busy}, {31'd0, e.busy});
  endtask

  task automatic push_lvl(input int n, input logic t, input logic b);
    for (int i = 0; i < n; i++) expq.push_back('{tx: t, busy: b});
  endtask

  task automatic push_frame(input logic [1:0] db,
                            input logic hp,
                            input logic [1:0] pm,
                            input logic es,
                            input int div,
                            input logic [7:0] d);
    int n;
    int ones;
    logic pb;
    logic bits[$];
    n = int'(db) + 5;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (hp) begin
      case (pm)
        2'b00: pb = 1'b0;
        2'b11: pb = 1'b1;
        2'b10: pb = (ones % 2 == 1);
        default: pb = (ones % 2 == 0);
      endcase
      bits.push_back(pb);
    end
    bits.push_back(1'b1);
    if (es) bits.push_back(1'b1);
    foreach (bits[i]) push_lvl(div + 1, bits[i], 1'b1);
  endtask

  task automatic set_cfg(input logic [1:0] db,
                         input logic hp,
                         input logic [1:0] pm,
                         input logic es,
                         input int div);
    dataBits     = db;
    hasParity    = hp;
    parityMode   = pm;
    extraStopBit = es;
    clockDivisor = 24'(div);
  endtask

  task automatic drain();
    while (expq.size() > 0) cyc();
  endtask

  task automatic run_frame(input logic [1:0] db,
                           input logic hp,
                           input logic [1:0] pm,
                           input logic es,
                           input int div,
                           input logic [7:0] d,
                           input bit scramble);
    set_cfg(db, hp, pm, es, div);
    dataIn    = d;
    dataValid = 1'b1;
    push_lvl(1, 1'b1, 1'b0);
    push_frame(db, hp, pm, es, div, d);
    cyc();
    dataValid = 1'b0;
    check("ready_low", {31'd0, dataReady}, 32'd0);
    cyc();
    check("ready_back", {31'd0, dataReady}, 32'd1);
    if (scramble) begin
      set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 1000)));
      dataIn = 8'($urandom);
    end
    drain();
    cyc();
  endtask

  initial begin
    rst       = 1'b1;
    sendBreak = 1'b0;
    dataValid = 1'b1;
    dataIn    = 8'h33;
    set_cfg(2'd3, 1'b0, 2'b00, 1'b0, 3);

    repeat (3) cyc();
    check("rst_ready", {31'd0, dataReady}, 32'd1);
    rst       = 1'b0;
    dataValid = 1'b0;
    repeat (5) cyc();
    check("post_rst_ready", {31'd0, dataReady}, 32'd1);

    run_frame(2'd3, 1'b0, 2'b00, 1'b0, 3, 8'hA5, 1'b0);
    run_frame(2'd2, 1'b1, 2'b10, 1'b0, 0, 8'hC1, 1'b0);
    run_frame(2'd3, 1'b1, 2'b01, 1'b1, 1, 8'h03, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run_frame(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), 8'($urandom), 1'b1);
    end

    // Back-to-back frames, 5 data bits with mark parity.
    set_cfg(2'd0, 1'b1, 2'b11, 1'b0, 2);
    dataIn    = 8'h55;
    dataValid = 1'b1;
    push_lvl(1, 1'b1, 1'b0);
    push_frame(2'd0, 1'b1, 2'b11, 1'b0, 2, 8'h55);
    push_frame(2'd0, 1'b1, 2'b11, 1'b0, 2, 8'h0F);
    cyc();
    dataIn = 8'h0F;
    check("b2b_ready_low", {31'd0, dataReady}, 32'd0);
    cyc();
    check("b2b_ready_back", {31'd0, dataReady}, 32'd1);
    cyc();
    dataValid = 1'b0;
    check("b2b_queued", {31'd0, dataReady}, 32'd0);
    drain();
    cyc();

    // Break requested mid-frame for 50 clk, byte queued during break.
    set_cfg(2'd3, 1'b0, 2'b00, 1'b0, 3);
    dataIn    = 8'h3C;
    dataValid = 1'b1;
    push_lvl(1, 1'b1, 1'b0);
    push_frame(2'd3, 1'b0, 2'b00, 1'b0, 3, 8'h3C);
    cyc();
    dataValid = 1'b0;
    repeat (10) cyc();
    sendBreak = 1'b1;
    drain();
    push_lvl(1, 1'b1, 1'b0);
    push_lvl(19, 1'b0, 1'b1);
    repeat (6) cyc();
    dataIn    = 8'h96;
    dataValid = 1'b1;
    cyc();
    dataValid = 1'b0;
    check("brk_queued", {31'd0, dataReady}, 32'd0);
    repeat (13) cyc();
    sendBreak = 1'b0;
    push_lvl(4, 1'b1, 1'b1);
    push_frame(2'd3, 1'b0, 2'b00, 1'b0, 3, 8'h96);
    drain();
    cyc();
    check("brk_done_ready", {31'd0, dataReady}, 32'd1);

    // Reset during DATA with a second byte held.
    set_cfg(2'd3, 1'b0, 2'b00, 1'b0, 3);
    dataIn    = 8'hF0;
    dataValid = 1'b1;
    push_lvl(1, 1'b1, 1'b0);
    push_frame(2'd3, 1'b0, 2'b00, 1'b0, 3, 8'hF0);
    cyc();
    dataIn = 8'h5A;
    cyc();
    cyc();
    dataValid = 1'b0;
    check("rst_held", {31'd0, dataReady}, 32'd0);
    repeat (8) cyc();
    rst = 1'b1;
    expq.delete();
    cyc();
    check("midrst_ready", {31'd0, dataReady}, 32'd1);
    rst = 1'b0;
    repeat (60) cyc();
    check("midrst_idle_ready", {31'd0, dataReady}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
